// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, frame geometry and line levels.
// Used by the transmitter today and by a future oversampling receiver.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    localparam logic UART_START_LVL = 1'b0;
    localparam logic UART_STOP_LVL  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

endpackage

// File: rtl/uart_transmitter_if.sv
// Byte handshake and serial-line bundle between a byte producer (master)
// and the UART transmitter (slave).
interface uart_transmitter_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] data;
    logic                      valid;
    logic                      ready;
    logic                      tx;
    logic                      busy;
    logic                      done;

    modport master (
        output data, valid,
        input  ready, tx, busy, done
    );

    modport slave (
        input  data, valid,
        output ready, tx, busy, done
    );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-timing counter: counts 0..CLKS_PER_BIT-1 and wraps.
// tick is a look-ahead flag: it is high when the coming cycle is the last
// cycle of a bit, so a consumer can register bit-boundary-aligned outputs
// without an extra cycle of latency. clr restarts the count at 0.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic ipclk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: restart on clear, wrap at the bit boundary.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end
    end

    assign tick = (cnt_d == CNT_LAST);

    // Counter register.
    always_ff @(posedge ipclk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmit side: start bit, 8 data bits LSB first, optional even parity
// bit (enabled by defining UART_TX_PARITY_EN), then STOP_BITS stop bits.
// All outputs are registered from the next-state values so each bit appears
// on tx in the cycle right after the edge that selects it.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1,
    parameter int STOP_BITS    = 1
) (
    input  logic                ipclk,
    input  logic                rst,
    uart_transmitter_if.slave   bus
);

    // Value of the 1-bit stop counter during the last stop bit.
    localparam logic STOP_LAST = (STOP_BITS == 2);

    uart_state_t               state_q, state_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0]                bit_idx_q, bit_idx_d;
    logic                      stop_cnt_q, stop_cnt_d;
    logic                      tx_q, tx_d;
    logic                      ready_q, ready_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      bnd_q;
    logic                      tick;
    logic                      accept;
`ifdef UART_TX_PARITY_EN
    logic                      parity_q, parity_d;
`endif

    assign accept = bus.valid && ready_q;

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .ipclk (ipclk),
        .rst   (rst),
        .clr   (accept),
        .tick  (tick)
    );

    // Next-state logic; acceptance (only possible in IDLE or the final stop
    // cycle) overrides whatever the current state chose.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        stop_cnt_d = stop_cnt_q;
        done_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            START: begin
                if (bnd_q) state_d = DATA;
            end
            DATA: begin
                if (bnd_q) begin
                    if (bit_idx_q == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                        stop_cnt_d = 1'b0;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[UART_DATA_BITS-1:1]};
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bnd_q) state_d = STOP;
            end
`endif
            STOP: begin
                if (bnd_q) begin
                    if (stop_cnt_q == STOP_LAST) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (accept) begin
            state_d    = START;
            shift_d    = bus.data;
            bit_idx_d  = 3'd0;
            stop_cnt_d = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_d   = ^bus.data;
`endif
        end
    end

    // Output decode from the next state, so registered outputs line up with it.
    always_comb begin
        tx_d = UART_STOP_LVL;
        case (state_d)
            START:   tx_d = UART_START_LVL;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = parity_d;
`endif
            default: tx_d = UART_STOP_LVL;
        endcase
        busy_d  = (state_d != IDLE);
        // Ready in idle, and in the very last cycle of the last stop bit so a
        // back-to-back byte starts without an idle gap.
        ready_d = (state_d == IDLE) ||
                  ((state_d == STOP) && (stop_cnt_d == STOP_LAST) && tick);
    end

    // State and output registers; reset abandons any frame in progress.
    always_ff @(posedge ipclk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_idx_q  <= 3'd0;
            stop_cnt_q <= 1'b0;
            tx_q       <= UART_STOP_LVL;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bnd_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bnd_q      <= tick;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity of the accepted byte, held for the whole frame.
    always_ff @(posedge ipclk or posedge rst) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

    assign bus.tx    = tx_q;
    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: two instances (1 clk/bit + 1 stop bit, and
// 4 clks/bit + 2 stop bits) driven with directed and random bytes, compared
// cycle by cycle against frames built from the serial framing rules.
module tb_uart_transmitter;

    logic ipclk = 1'b0;
    logic rst   = 1'b1;

    always #5 ipclk = ~ipclk;

    uart_transmitter_if bus0 ();
    uart_transmitter_if bus1 ();

    logic [7:0] data0 = 8'h00;
    logic [7:0] data1 = 8'h00;
    logic       valid0 = 1'b0;
    logic       valid1 = 1'b0;

    assign bus0.data  = data0;
    assign bus0.valid = valid0;
    assign bus1.data  = data1;
    assign bus1.valid = valid1;

    logic [1:0] tx_s, ready_s, busy_s, done_s;
    assign tx_s    = {bus1.tx,    bus0.tx};
    assign ready_s = {bus1.ready, bus0.ready};
    assign busy_s  = {bus1.busy,  bus0.busy};
    assign done_s  = {bus1.done,  bus0.done};

    uart_transmitter #(.CLKS_PER_BIT(1), .STOP_BITS(1)) dut0 (
        .ipclk (ipclk),
        .rst   (rst),
        .bus   (bus0)
    );

    uart_transmitter #(.CLKS_PER_BIT(4), .STOP_BITS(2)) dut1 (
        .ipclk (ipclk),
        .rst   (rst),
        .bus   (bus1)
    );

    int checks   = 0;
    int failures = 0;

    function automatic int cpb(input int s);
        return (s == 0) ? 1 : 4;
    endfunction

    function automatic int stb(input int s);
        return (s == 0) ? 1 : 2;
    endfunction

    task automatic step();
        @(posedge ipclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input int s, input logic v, input logic [7:0] d);
        if (s == 0) begin
            valid0 = v;
            data0  = d;
        end else begin
            valid1 = v;
            data1  = d;
        end
    endtask

    task automatic wait_ready(input int s);
        int n = 0;
        while (!ready_s[s] && n < 64) begin
            step();
            n++;
        end
        check($sformatf("s%0d wait_ready", s), 32'(ready_s[s]), 32'd1);
    endtask

    // Send n bytes back to back (valid held high) and compare every cycle
    // against the expected serial frames plus two idle cycles afterwards.
    task automatic run_frames(input int s, input int n,
                              input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        logic [7:0] b [3];
        logic e_tx[$], e_busy[$], e_done[$], e_rdy[$];
        int fl;
        int done_cnt;
        b[0] = b0; b[1] = b1; b[2] = b2;
        fl = (9 + stb(s)) * cpb(s);
        for (int j = 0; j < n; j++) begin
            for (int c = 0; c < fl; c++) begin
                int bp;
                bp = c / cpb(s);
                if (bp == 0)      e_tx.push_back(1'b0);
                else if (bp <= 8) e_tx.push_back(b[j][bp-1]);
                else              e_tx.push_back(1'b1);
                e_busy.push_back(1'b1);
                e_done.push_back((j > 0) && (c == 0));
                e_rdy.push_back(c == fl - 1);
            end
        end
        e_tx.push_back(1'b1); e_busy.push_back(1'b0); e_done.push_back(1'b1); e_rdy.push_back(1'b1);
        e_tx.push_back(1'b1); e_busy.push_back(1'b0); e_done.push_back(1'b0); e_rdy.push_back(1'b1);

        wait_ready(s);
        set_in(s, 1'b1, b[0]);
        step();
        done_cnt = 0;
        for (int k = 0; k < e_tx.size(); k++) begin
            if ((k % fl == 0) && (k < n * fl)) begin
                if (k / fl + 1 < n) set_in(s, 1'b1, b[k / fl + 1]);
                else                set_in(s, 1'b0, 8'($urandom));
            end
            check($sformatf("s%0d b%02h tx k%0d", s, b0, k),    32'(tx_s[s]),    32'(e_tx[k]));
            check($sformatf("s%0d b%02h busy k%0d", s, b0, k),  32'(busy_s[s]),  32'(e_busy[k]));
            check($sformatf("s%0d b%02h done k%0d", s, b0, k),  32'(done_s[s]),  32'(e_done[k]));
            check($sformatf("s%0d b%02h ready k%0d", s, b0, k), 32'(ready_s[s]), 32'(e_rdy[k]));
            done_cnt += int'(done_s[s]);
            step();
        end
        check($sformatf("s%0d done_pulses", s), 32'(done_cnt), 32'(n));
        $display("frames s%0d n=%0d bytes=%02h %02h %02h cycles=%0d", s, n, b0, b1, b2, e_tx.size());
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset values for both instances.
        step();
        step();
        for (int s = 0; s < 2; s++) begin
            check($sformatf("s%0d rst tx", s),    32'(tx_s[s]),    32'd1);
            check($sformatf("s%0d rst ready", s), 32'(ready_s[s]), 32'd0);
            check($sformatf("s%0d rst busy", s),  32'(busy_s[s]),  32'd0);
            check($sformatf("s%0d rst done", s),  32'(done_s[s]),  32'd0);
        end
        rst = 1'b0;
        step();
        check("s0 ready_after_rst", 32'(ready_s[0]), 32'd1);
        check("s1 ready_after_rst", 32'(ready_s[1]), 32'd1);
        $display("reset released, both ready");

        // Directed frames.
        run_frames(0, 1, 8'hA5, 8'h00, 8'h00);
        run_frames(1, 1, 8'h01, 8'h00, 8'h00);
        run_frames(0, 2, 8'h55, 8'hAA, 8'h00);
        run_frames(1, 2, 8'h55, 8'hAA, 8'h00);

        // Reset in the middle of a frame on both instances.
        set_in(0, 1'b1, 8'hFF);
        set_in(1, 1'b1, 8'h00);
        step();
        set_in(0, 1'b0, 8'h00);
        set_in(1, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) step();
        check("s0 busy_before_rst", 32'(busy_s[0]), 32'd1);
        check("s1 tx_before_rst",   32'(tx_s[1]),   32'd0);
        rst = 1'b1;
        #1;
        for (int s = 0; s < 2; s++) begin
            check($sformatf("s%0d midrst tx", s),    32'(tx_s[s]),    32'd1);
            check($sformatf("s%0d midrst ready", s), 32'(ready_s[s]), 32'd0);
            check($sformatf("s%0d midrst busy", s),  32'(busy_s[s]),  32'd0);
            check($sformatf("s%0d midrst done", s),  32'(done_s[s]),  32'd0);
        end
        step();
        rst = 1'b0;
        step();
        check("s0 ready_after_midrst", 32'(ready_s[0]), 32'd1);
        check("s1 ready_after_midrst", 32'(ready_s[1]), 32'd1);
        $display("mid-frame reset handled");
        run_frames(0, 1, 8'h12, 8'h00, 8'h00);

        // Random bytes and burst lengths.
        for (int r = 0; r < 8; r++) begin
            run_frames(r % 2, int'($urandom_range(1, 3)),
                       8'($urandom), 8'($urandom), 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serial transmit side of the UART link. Accepts a byte on a valid/ready handshake and shifts it out on `tx` as one start bit (0), eight data bits LSB first, an optional parity bit, and one or two stop bits (1). With default parameters (one bit per `ipclk` cycle, one stop bit, no parity), its frame is exactly what `uartreceiver` expects, so the pair can be looped back directly.

## Interface
- `CLKS_PER_BIT`, default 1: `ipclk` cycles per serial bit; must be ≥1, 0 is illegal.
- `STOP_BITS`, default 1: stop bits per frame; legal values are 1 or 2.
- `ipclk` input, 1: the only clock; all logic on its rising edge.
- `rst` input, 1: asynchronous, active-high reset.
- `data` input, 8: byte to send; sampled only on acceptance.
- `valid` input, 1: a byte is offered on `data`.
- `ready` output, 1: the transmitter can accept a byte this cycle.
- `tx` output, 1: serial line; idles high.
- `busy` output, 1: high from the first start-bit cycle through the final stop-bit cycle.
- `done` output, 1: one-cycle pulse in the cycle after the last stop-bit cycle.

## Operation
- Reset values: `tx`=1, `ready`=0, `busy`=0, `done`=0, state IDLE, counters 0.
- `tx` and all outputs are registered; no combinational path from inputs to outputs.
- States:
  - IDLE: `tx`=1, `ready`=1 from the first clock after `rst` deasserts.
  - START: `tx`=0.
  - DATA: `tx`=bit[`bit_idx`], with `bit_idx` running 0..7.
  - PARITY: present only with the macro (see Configuration).
  - STOP: `tx`=1.
- Acceptance happens at a rising edge where `valid && ready`. On acceptance:
  - `data` is latched into the shift register and the next state is START.
  - Later changes on `data` or `valid` during the frame are ignored.
- Bit timing: a baud counter counts 0..`CLKS_PER_BIT`-1. A bit boundary is reached when the counter hits `CLKS_PER_BIT`-1; the counter then wraps to 0.
- Transitions on a bit boundary:
  - START→DATA.
  - DATA→DATA while `bit_idx`<7; the register shifts right by one.
  - DATA→PARITY when the macro is defined, otherwise DATA→STOP.
  - PARITY→STOP.
  - STOP→STOP until `STOP_BITS` bits have been sent, then →IDLE.
- Back-to-back frames:
  - `ready` is also high during the final cycle of the last stop bit.
  - An acceptance in that cycle goes straight to START, with no idle gap.
  - `done` still pulses in that case.
- When `valid` is low at the end of a frame, the block enters IDLE with `tx`=1.
- Widths:
  - Baud counter: `$clog2(CLKS_PER_BIT)` bits, with a minimum of 1.
  - `bit_idx`: 3 bits.
  - Stop counter: 1 bit.
- Reset mid-frame:
  - `tx` returns to 1 immediately (asynchronous) and `busy`/`ready`/`done` drop to 0.
  - The partial frame is abandoned, not resumed.

## Timing
- Acceptance at edge N: `tx`=0 and `busy`=1 from edge N+1.
- Each bit is held exactly `CLKS_PER_BIT` cycles.
- Frame length is (10 + P + `STOP_BITS` − 1) × `CLKS_PER_BIT` cycles, where P=1 with parity and 0 without.
- `done` is high for one cycle, coincident with the first cycle after STOP; `busy` is 0 in that cycle unless a new frame was accepted.
- `ready` is 0 from edge N+1 until the final stop-bit cycle.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - A PARITY state sits between DATA and STOP.
  - It transmits even parity, the XOR of the 8 data bits.
  - Frame grows by one bit. This frame is not compatible with `uartreceiver`.
- `UART_TX_PARITY_EN` undefined: no PARITY state and no parity logic is synthesized.

## Structure
- Shared package `uart_pkg` holds:
  - State enum `uart_state_t`: IDLE, START, DATA, PARITY, STOP.
  - `UART_DATA_BITS`=8.
  - Line levels `UART_START_LVL`=0 and `UART_STOP_LVL`=1.
- Sub-module `uart_baud_gen` (parameter `CLKS_PER_BIT`; ports `ipclk`, `rst`, `clr`, `tick`):
  - Provides the bit-boundary tick.
  - Is cleared on acceptance.
  - Is reusable by a future oversampling receiver.

## Test plan
- Default parameters, send 0xA5 → `tx` per cycle is 0,1,0,1,0,0,1,0,1,1. `done` pulses on the 11th cycle after acceptance.
- Loopback into `uartreceiver`, send 0x3C → receiver presents `data`=0x3C with `ready`=1.
- `CLKS_PER_BIT`=4, `STOP_BITS`=2, send 0x01 → start bit low 4 cycles, then d0 high 4 cycles, then d1..d7 low 28 cycles, then stop high 8 cycles; `busy` high for 44 cycles.
- `valid` held high with 0x55 then 0xAA → second start bit immediately follows the first frame's stop bit. No idle cycle; exactly 2 `done` pulses.
- Assert `rst` during data bit 3 of 0xFF → `tx`=1 and `ready`=0 immediately. After release, `ready`=1 on the next edge and a fresh 0x12 frame is correct.
- With `UART_TX_PARITY_EN`: send 0x07 → parity bit 1; send 0x03 → parity bit 0. Frame is 11 bits.
